rl_lj_pair_dispatcher: RTL
==========================

# rl_lj_pair_dispatcher

Pair-issuing front end for the range-limited LJ force pipeline. It holds one cell's particle positions in a local register file and streams every unique pair (i, j), with i < j, as ref/neighbor position sets. A valid/ready handshake drives the 1st-order LJ evaluation tile's ivalid/iready side. It is the transmitter for the evaluator's pair input and reports completion so a host FSM can swap cells.

## Interface

Parameters:
- DATA_WIDTH, 32, width of each position coordinate (FP32, passed through untouched)
- ADDR_WIDTH, 6, particle index width; capacity P = 2^ADDR_WIDTH (64)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  position write strobe; honored only when busy=0
- wr_addr  in  ADDR_WIDTH  particle slot written
- wr_x, wr_y, wr_z  in  DATA_WIDTH each  position written to slot wr_addr
- particle_num  in  ADDR_WIDTH+1  particle count N; sampled on accepted start; values > P saturate to P
- start  in  1  begin a dispatch run; honored only when busy=0
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a run completes
- ovalid  out  1  pair on outputs is valid (to evaluator ivalid)
- iready  in  1  downstream can accept (from evaluator oready)
- ref_x, ref_y, ref_z  out  DATA_WIDTH each  position of particle i
- neighbor_x, neighbor_y, neighbor_z  out  DATA_WIDTH each  position of particle j
- ref_id, neighbor_id  out  ADDR_WIDTH each  indices i, j of the current pair

## Operation

- Storage: P×3×DATA_WIDTH register file, combinational read. A write lands at the edge where wr_en=1 and busy=0. Contents survive runs and are not cleared by reset.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches N. If N ≥ 2, go to RUN with i=0, j=1. If N < 2, go to DRAIN with no pair issued.
  - RUN: output slot is free when ovalid=0 or iready=1. When free, load positions[i], positions[j], i, j into the output registers, set ovalid=1, then advance the index.
    - If j < N-1: j ← j+1.
    - Else: i ← i+1, j ← i+2.
    - If the loaded pair was (N-2, N-1): go to DRAIN.
  - DRAIN: completes at the first edge where ovalid=0 or iready=1. At that edge: ovalid←0, done←1 for one cycle, go to IDLE.
- Order: i-major ascending, j ascending. Total N(N-1)/2 pairs; no self pairs, no duplicates.
- Handshake: a transfer occurs at an edge with ovalid=1 and iready=1. While ovalid=1 and iready=0, all outputs (data, ids) hold stable. ovalid never deasserts without a transfer, except on reset.
- start while busy=1: ignored. wr_en while busy=1: ignored, memory unchanged.
- Reset (resetn=0, any time): state=IDLE, ovalid=0, done=0, busy=0, i=j=0, output data/ids=0. Takes effect immediately. An in-flight pair is dropped with no done.

## Timing

- Start is accepted at edge E0. RUN begins after E0. The first pair is registered at E1, so ovalid=1 in the cycle after E1.
- With iready held high: one pair per cycle, no bubbles, including across i increments.
- The last pair transfers at edge Ek. done=1 in the cycle after Ek, busy=0 from the same cycle. A new start is accepted in that same cycle.
- N < 2: start at E0 → DRAIN, then done pulses after E1, and ovalid never rises.
- The run length in cycles, with iready held high, is N(N-1)/2 + 2 from start edge to done.

## Test plan

- Load slots 0..3 with x=1.0,2.0,3.0,4.0 and y=z=0. Start with N=4, iready=1. Expect 6 consecutive transfers with (ref_id, neighbor_id) = (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) and matching ref_x/neighbor_x. Expect done one cycle after the last transfer.
- Same load, iready toggling 1,0,0,1,... Outputs stay stable during each stall, exactly 6 transfers occur in the same order, and done follows the final transfer.
- N=1, then N=0: no ovalid ever. done pulses exactly once, two cycles after the start edge.
- N=64 and N=100 (saturates to 64), iready=1: 2016 transfers, the last is (62,63), and done follows.
- Issue wr_en to slot 2 and a second start mid-run. Both are ignored: the pair sequence and slot-2 data are unchanged, and there is only one done.
- Assert resetn=0 mid-run with ovalid=1: ovalid, busy and done drop immediately. After release, start with N=3 gives (0,1),(0,2),(1,2) using the preserved memory contents.

Source files
------------

// File: rtl/rl_lj_pair_dispatcher.sv
// Pair-issuing front end for the range-limited LJ pipeline: holds one cell's
// positions and streams every unique (i, j), i < j, over a valid/ready link.
module rl_lj_pair_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_x,
  input  logic [DATA_WIDTH-1:0] wr_y,
  input  logic [DATA_WIDTH-1:0] wr_z,
  input  logic [ADDR_WIDTH:0]   particle_num,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ovalid,
  input  logic                  iready,
  output logic [DATA_WIDTH-1:0] ref_x,
  output logic [DATA_WIDTH-1:0] ref_y,
  output logic [DATA_WIDTH-1:0] ref_z,
  output logic [DATA_WIDTH-1:0] neighbor_x,
  output logic [DATA_WIDTH-1:0] neighbor_y,
  output logic [DATA_WIDTH-1:0] neighbor_z,
  output logic [ADDR_WIDTH-1:0] ref_id,
  output logic [ADDR_WIDTH-1:0] neighbor_id
);

  localparam int P  = 1 << ADDR_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] P_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic                  ovalid_q, ovalid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic [DATA_WIDTH-1:0] nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
  logic [ADDR_WIDTH-1:0] rid_q, rid_d, nid_q, nid_d;

  logic [DATA_WIDTH-1:0] pos_x_q [P];
  logic [DATA_WIDTH-1:0] pos_y_q [P];
  logic [DATA_WIDTH-1:0] pos_z_q [P];

  logic [ADDR_WIDTH:0]   n_start;
  logic [ADDR_WIDTH:0]   i_ext, j_ext;
  logic                  slot_free;
  logic                  last_pair;

  assign busy = (state_q != S_IDLE);

  // Position file is deliberately outside reset so contents survive it.
  always_ff @(posedge clock) begin
    if (wr_en && !busy) begin
      pos_x_q[wr_addr] <= wr_x;
      pos_y_q[wr_addr] <= wr_y;
      pos_z_q[wr_addr] <= wr_z;
    end
  end

  always_comb begin
    n_start   = (particle_num > P_CNT) ? P_CNT : particle_num;
    i_ext     = {1'b0, i_q};
    j_ext     = {1'b0, j_q};
    slot_free = !ovalid_q || iready;
    last_pair = (i_ext == n_q - CW'(2)) && (j_ext == n_q - CW'(1));
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    n_d      = n_q;
    ovalid_d = ovalid_q;
    done_d   = 1'b0;
    rx_d     = rx_q;
    ry_d     = ry_q;
    rz_d     = rz_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    nz_d     = nz_q;
    rid_d    = rid_q;
    nid_d    = nid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n_start;
          i_d     = '0;
          j_d     = AW'(1);
          state_d = (n_start >= CW'(2)) ? S_RUN : S_DRAIN;
        end
      end
      S_RUN: begin
        if (slot_free) begin
          rx_d     = pos_x_q[i_q];
          ry_d     = pos_y_q[i_q];
          rz_d     = pos_z_q[i_q];
          nx_d     = pos_x_q[j_q];
          ny_d     = pos_y_q[j_q];
          nz_d     = pos_z_q[j_q];
          rid_d    = i_q;
          nid_d    = j_q;
          ovalid_d = 1'b1;
          if (j_ext < n_q - CW'(1)) begin
            j_d = j_q + AW'(1);
          end else begin
            i_d = i_q + AW'(1);
            j_d = i_q + AW'(2);
          end
          if (last_pair) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (slot_free) begin
          ovalid_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      n_q      <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      rx_q     <= '0;
      ry_q     <= '0;
      rz_q     <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      nz_q     <= '0;
      rid_q    <= '0;
      nid_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      n_q      <= n_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      rz_q     <= rz_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      nz_q     <= nz_d;
      rid_q    <= rid_d;
      nid_q    <= nid_d;
    end
  end

  assign done        = done_q;
  assign ovalid      = ovalid_q;
  assign ref_x       = rx_q;
  assign ref_y       = ry_q;
  assign ref_z       = rz_q;
  assign neighbor_x  = nx_q;
  assign neighbor_y  = ny_q;
  assign neighbor_z  = nz_q;
  assign ref_id      = rid_q;
  assign neighbor_id = nid_q;

endmodule
